// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants, IR field positions and fetch FSM encoding
package cpu_pkg;

  localparam logic [3:0] OP_MVI = 4'b1100;
  localparam logic [3:0] OP_LDA = 4'b1101;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OP1_MSB = 11;
  localparam int OP1_LSB = 9;
  localparam int OP2_MSB = 8;
  localparam int OP2_LSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // Opcodes that carry an immediate in a second instruction word.
  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OP_MVI) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with natural wrap at 2^ADDR_W-1
module pc_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (pc_inc) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with IR/imm capture; FETCH_TIMEOUT_EN adds a WAIT timeout
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              ins_load,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic [15:0]       rom_data,
  input  logic              rom_valid,
  output logic [3:0]        opcode,
  output logic [2:0]        op1_sel,
  output logic [2:0]        op2_sel,
  output logic [15:0]       imm,
  output logic              two_word,
  output logic              ins_ready,
  output logic              busy,
  output logic              fetch_err
);

  import cpu_pkg::*;

  fetch_state_e      state;
  logic [15:0]       ir;
  logic              pend2;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_shadow;
  logic              load_pend;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC != 0);
  assign fetch_err  = 1'b0;
`endif

  pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .pc_inc (pc_inc),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rom_addr    <= '0;
      rom_req     <= 1'b0;
      ir          <= '0;
      imm         <= '0;
      pend2       <= 1'b0;
      ins_ready   <= 1'b0;
      addr_shadow <= '0;
      load_pend   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt     <= '0;
      fetch_err   <= 1'b0;
`endif
    end else begin
      ins_ready <= 1'b0;
      // A snapshot taken mid-fetch is held back so rom_addr stays put until IDLE.
      if (state != ST_IDLE && pc_load) begin
        addr_shadow <= pc;
        load_pend   <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pc_load) begin
            rom_addr <= pc;
          end else if (load_pend) begin
            rom_addr <= addr_shadow;
          end
          load_pend <= 1'b0;
          if (ins_load) begin
            state   <= ST_REQ;
            rom_req <= 1'b1;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (rom_valid) begin
            if (pend2) begin
              imm   <= rom_data;
              pend2 <= 1'b0;
            end else begin
              ir    <= rom_data;
              pend2 <= is_two_word(rom_data[OPC_MSB:OPC_LSB]);
            end
            ins_ready <= 1'b1;
            rom_req   <= 1'b0;
            state     <= ST_IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rom_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
`endif
        end
        default: begin
          state   <= ST_IDLE;
          rom_req <= 1'b0;
        end
      endcase
    end
  end

  logic unused_ir;
  assign unused_ir = ^ir[OP2_LSB-1:0];

  assign busy     = (state != ST_IDLE);
  assign opcode   = ir[OPC_MSB:OPC_LSB];
  assign op1_sel  = ir[OP1_MSB:OP1_LSB];
  assign op2_sel  = ir[OP2_MSB:OP2_LSB];
  assign two_word = is_two_word(ir[OPC_MSB:OPC_LSB]);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_load = 1'b0;
  logic        pc_inc = 1'b0;
  logic        ins_load = 1'b0;
  logic        rom_valid = 1'b0;
  logic [15:0] rom_data = 16'h0;
  logic [7:0]  rom_addr;
  logic        rom_req;
  logic [3:0]  opcode;
  logic [2:0]  op1_sel;
  logic [2:0]  op2_sel;
  logic [15:0] imm;
  logic        two_word;
  logic        ins_ready;
  logic        busy;
  logic        fetch_err;

  fetch_unit #(.ADDR_W(8), .TMO_CYC(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .ins_load  (ins_load),
    .rom_addr  (rom_addr),
    .rom_req   (rom_req),
    .rom_data  (rom_data),
    .rom_valid (rom_valid),
    .opcode    (opcode),
    .op1_sel   (op1_sel),
    .op2_sel   (op2_sel),
    .imm       (imm),
    .two_word  (two_word),
    .ins_ready (ins_ready),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int rdy_cnt = 0;
  int req_cnt = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (ins_ready) rdy_cnt = rdy_cnt + 1;
    if (rom_req && !req_prev) req_cnt = req_cnt + 1;
    req_prev = rom_req;
  end

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] imm;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_ir = 16'h0;
  logic [15:0] m_imm = 16'h0;
  logic        m_pend = 1'b0;
  logic [7:0]  m_pc = 8'h0;
  logic [7:0]  m_addr = 8'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic m_two(input logic [15:0] w);
    return (w[15:12] == 4'b1100) || (w[15:12] == 4'b1101);
  endfunction

  task automatic model_capture(input logic [15:0] w);
    if (m_pend) begin
      m_imm  = w;
      m_pend = 1'b0;
    end else begin
      m_ir   = w;
      m_pend = m_two(w);
    end
    sb.push_back('{ir: m_ir, imm: m_imm});
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_opcode"}, opcode, e.ir[15:12]);
      chk({tag, "_op1"}, op1_sel, e.ir[11:9]);
      chk({tag, "_op2"}, op2_sel, e.ir[8:6]);
      chk({tag, "_imm"}, imm, e.imm);
      chk({tag, "_two_word"}, two_word, m_two(e.ir));
    end
  endtask

  task automatic pc_step(input int n);
    pc_inc = 1'b1;
    repeat (n) tick();
    pc_inc = 1'b0;
    m_pc = m_pc + n[7:0];
  endtask

  task automatic snap(input string tag);
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    m_addr = m_pc;
    chk(tag, rom_addr, m_addr);
  endtask

  task automatic do_fetch(input string tag, input logic [15:0] w, input int dly, input logic with_load);
    int c0;
    c0 = cyc;
    ins_load = 1'b1;
    pc_load  = with_load;
    tick();
    ins_load = 1'b0;
    pc_load  = 1'b0;
    if (with_load) m_addr = m_pc;
    chk({tag, "_req"}, {busy, rom_req}, 2'b11);
    chk({tag, "_addr"}, rom_addr, m_addr);
    tick();
    repeat (dly) tick();
    rom_valid = 1'b1;
    rom_data  = w;
    model_capture(w);
    tick();
    rom_valid = 1'b0;
    rom_data  = 16'h0;
    chk({tag, "_ready"}, ins_ready, 1'b1);
    chk({tag, "_latency"}, cyc - c0, 3 + dly);
    sb_check(tag);
    tick();
    chk({tag, "_idle"}, {ins_ready, busy, rom_req}, 3'b000);
  endtask

  initial begin
    int rc0;
    int r0;
    logic [7:0] a_hold;
    logic [7:0] shadow;

    repeat (3) tick();
    chk("rst_rom_req", rom_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ins_ready, 1'b0);
    chk("rst_opcode", opcode, 4'b0000);
    chk("rst_imm", imm, 16'h0);
    chk("rst_addr", rom_addr, 8'h00);
    chk("rst_err", fetch_err, 1'b0);
    chk("rst_two", two_word, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic single-word fetch, ROM answers in the first WAIT cycle
    snap("snap0");
    do_fetch("f0a40", 16'h0A40, 0, 1'b0);
    chk("f0a40_op1_lit", op1_sel, 3'd5);
    chk("f0a40_op2_lit", op2_sel, 3'd1);

    // Two-word instruction: opcode word then immediate
    do_fetch("fc200", 16'hC200, 1, 1'b0);
    chk("fc200_two", two_word, 1'b1);
    do_fetch("f1234", 16'h1234, 2, 1'b0);
    chk("f1234_imm_lit", imm, 16'h1234);
    chk("f1234_ir_hold", opcode, 4'hC);
    do_fetch("fnext", 16'h0A40, 0, 1'b0);
    chk("fnext_pend_clr", two_word, 1'b0);

    // PC increment, simultaneous inc+load, wrap
    pc_step(5);
    pc_inc  = 1'b1;
    pc_load = 1'b1;
    tick();
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    m_addr = m_pc;
    m_pc   = m_pc + 8'd1;
    chk("inc_load_addr", rom_addr, 8'd5);
    snap("inc_load_pc");
    pc_step(249);
    snap("pc_ff");
    pc_step(1);
    snap("pc_wrap");

    // ins_load with pc_load fetches from the new address
    pc_step(3);
    do_fetch("fload", 16'h3E40, 0, 1'b1);

    // Busy: ins_load ignored, rom_addr stable, deferred snapshot lands in IDLE
    rc0 = req_cnt;
    r0  = rdy_cnt;
    a_hold = rom_addr;
    ins_load = 1'b1;
    tick();
    ins_load = 1'b0;
    tick();
    ins_load = 1'b1;
    pc_inc   = 1'b1;
    pc_load  = 1'b1;
    tick();
    ins_load = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    shadow = m_pc;
    m_pc   = m_pc + 8'd1;
    chk("busy_addr_stable", rom_addr, a_hold);
    chk("busy_still", busy, 1'b1);
    rom_valid = 1'b1;
    rom_data  = 16'h2280;
    model_capture(16'h2280);
    tick();
    rom_valid = 1'b0;
    rom_data  = 16'h0;
    sb_check("fbusy");
    repeat (3) tick();
    m_addr = shadow;
    chk("busy_one_fetch", req_cnt - rc0, 1);
    chk("busy_one_ready", rdy_cnt - r0, 1);
    chk("busy_no_refetch", busy, 1'b0);
    chk("busy_deferred_addr", rom_addr, m_addr);

    // WAIT with no rom_valid for TMO_CYC cycles
    r0 = rdy_cnt;
    ins_load = 1'b1;
    tick();
    ins_load = 1'b0;
    tick();
    repeat (14) tick();
    chk("tmo_wait14_busy", busy, 1'b1);
    tick();
`ifdef FETCH_TIMEOUT_EN
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_err", fetch_err, 1'b1);
    chk("tmo_req", rom_req, 1'b0);
    tick();
    chk("tmo_no_ready", rdy_cnt - r0, 0);
    chk("tmo_ir_hold", opcode, m_ir[15:12]);
    chk("tmo_imm_hold", imm, m_imm);
    chk("tmo_err_sticky", fetch_err, 1'b1);
`else
    chk("notmo_busy", busy, 1'b1);
    chk("notmo_err", fetch_err, 1'b0);
    rom_valid = 1'b1;
    rom_data  = 16'h4A80;
    model_capture(16'h4A80);
    tick();
    rom_valid = 1'b0;
    rom_data  = 16'h0;
    sb_check("fnotmo");
    tick();
`endif

    // Asynchronous reset while in WAIT
    ins_load = 1'b1;
    tick();
    ins_load = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_req", rom_req, 1'b0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_opcode", opcode, 4'b0000);
    chk("rstw_err", fetch_err, 1'b0);
    tick();
    rst_n = 1'b1;
    m_ir = 16'h0;
    m_imm = 16'h0;
    m_pend = 1'b0;
    m_pc = 8'h0;
    m_addr = 8'h0;
    tick();
    chk("rstw_addr", rom_addr, 8'h00);
    chk("rstw_imm", imm, 16'h0);
    pc_step(2);
    do_fetch("fpost", 16'hD000, 0, 1'b1);
    chk("fpost_two", two_word, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
